fetch_pc_sequencer: RTL and testbench
=====================================

Name: fetch_pc_sequencer

Overview:
- Owns the program counter of the 5-stage pipelined CPU and sequences instruction fetch from instruction memory.
- Selects next PC among sequential, jump, branch, return-from-handler, interrupt vector and exception vector.
- Tracks kernel mode, saves the return address into $k0, and drives IF/ID and ID/EX flushes.
- Sits between the hazard unit, ID/EX redirect logic, the timer IRQ line and the instruction memory address input.

Parameters:
- RESET_VEC, 32'h0000_0000, PC after reset (Main entry jump).
- IRQ_VEC, 32'h0000_0004, interrupt handler entry (Interrupt jump slot).
- EXC_VEC, 32'h0000_0008, undefined-instruction entry (Abnormal jump slot).
- SYNC_STAGES, 2, flops in the irq_in synchroniser (min 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  1  timer interrupt request, level, asynchronous to clk.
- stall  in  1  load-use stall from hazard unit; holds PC and IF/ID.
- id_valid  in  1  ID stage holds a real, non-flushed instruction.
- id_pc  in  32  PC of the instruction in ID.
- id_undef  in  1  ID instruction is an undefined opcode/funct.
- jump_req  in  1  j/jal/jr in ID (excluding return jr $k0).
- jump_target  in  32  target for jump_req.
- eret_req  in  1  jr $k0 in ID while kernel=1.
- eret_target  in  32  $k0 value forwarded to ID.
- branch_req  in  1  taken branch resolved in EX.
- branch_target  in  32  target for branch_req.
- pc  out  32  current fetch address to instruction memory.
- pc_plus4  out  32  pc+4, wraps modulo 2^32.
- kernel  out  1  1 while inside a handler; interrupts masked.
- flush_if  out  1  kill the IF/ID latch this cycle.
- flush_id  out  1  kill the ID/EX latch this cycle.
- k0_we  out  1  one-cycle write strobe for $k0 (reg 26).
- k0_data  out  32  return address to write to $k0.
- irq_ack  out  1  one-cycle pulse on interrupt acceptance.

Behaviour:
- Reset (async assert, sync release): pc=RESET_VEC, kernel=0, k0_we=0, k0_data=0, irq_ack=0, synchroniser cleared. flush_if and flush_id are combinational, 0 while reset is low.
- Interrupt request: irq_in passes through SYNC_STAGES flops to form irq_s. irq_pend = irq_s & ~kernel. It is level-based, with no latch; the handler clears the timer before returning.
- Next-PC priority, evaluated combinationally each cycle, highest first:
  1. branch_req: pc<=branch_target; flush_if=1, flush_id=1. Overrides stall and everything in ID.
  2. exc = id_valid & id_undef & ~stall: pc<=EXC_VEC; kernel<=1; k0_data<=id_pc+4; flush_if=1, flush_id=1. Taken even when kernel=1.
  3. irq = irq_pend & id_valid & ~stall: pc<=IRQ_VEC; kernel<=1; k0_data<=id_pc; irq_ack=1; flush_if=1, flush_id=1. The ID instruction is re-executed on return.
  4. eret_req & ~stall: pc<=eret_target; kernel<=0; flush_if=1.
  5. jump_req & ~stall: pc<=jump_target; flush_if=1.
  6. stall: pc holds; no flushes.
  7. Otherwise pc<=pc+4.
- k0_we is registered: it pulses high for exactly the cycle after exc or irq acceptance, with k0_data valid in that cycle. The register file gives k0_we priority over the WB write to reg 26 in that cycle.
- irq is never taken while id_valid=0, e.g. the cycle after a flush. It is taken at the first cycle with id_valid=1, ~stall and no branch_req.
- Simultaneous branch_req and irq: the branch wins; irq is re-evaluated next cycles.
- Simultaneous exc and irq: exc wins; irq stays masked until eret.
- eret and irq pending in the same cycle: eret accepted. The irq is taken at the earliest cycle after kernel=0 with id_valid=1 (the return-target instruction).
- Async reset mid-handler: returns to the reset state; kernel=0, pending k0 write dropped.
- All PC arithmetic is 32-bit unsigned modulo 2^32; bits [1:0] are passed through unchanged (no alignment check).

Test Plan:
- Reset then free-run, no requests -> pc sequence 0,4,8,12; kernel=0; no flushes; pc_plus4 = pc+4 every cycle.
- irq_in rises while id_pc=0x30, id_valid=1 -> after 2 sync cycles, one cycle with flush_if=flush_id=irq_ack=1 and next pc=0x4; following cycle k0_we=1, k0_data=0x30; kernel=1.
- irq_in held high in kernel; eret_req with eret_target=0x30 -> no second entry while kernel=1; pc=0x30, kernel=0. Re-entry (k0_data=0x30) occurs on the first cycle ID holds 0x30 with id_valid=1.
- id_undef with id_pc=0x50 -> pc=0x8, k0_data=0x54, kernel=1, flush_id=1.
- branch_req (target 0x5C) in the same cycle as irq and stall=1 -> pc=0x5C, irq_ack=0. Then with stall=1 and irq pending, pc holds and irq_ack stays 0. irq is taken once stall=0 and id_valid=1.
- Assert reset while kernel=1 and k0_we is pending -> pc=0x0, kernel=0, k0_we=0 immediately, independent of clk.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// Purpose: owns the fetch PC, picks the next PC and tracks kernel mode; also drives the pipeline flushes and the $k0 return-address write.
// Latency: pc, kernel and k0_we/k0_data are registered (1 cycle); flush_if, flush_id and irq_ack are combinational in the deciding cycle.
// Backpressure: stall holds pc and suppresses every redirect except a branch resolved in EX.
//
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   irq_in                          asynchronous level interrupt request
//   stall, id_valid, id_pc, id_undef, jump_req/jump_target,
//   eret_req/eret_target, branch_req/branch_target   redirect inputs
//   pc, pc_plus4                    fetch address and its successor
//   kernel                          set while inside a handler; masks the interrupt
//   flush_if, flush_id              kill the IF/ID and ID/EX latches
//   k0_we, k0_data                  one-cycle write of the return address to $k0
//   irq_ack                         pulses when an interrupt is accepted
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC     = 32'h0000_0004,
  parameter logic [31:0] EXC_VEC     = 32'h0000_0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_undef,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        eret_req,
  input  logic [31:0] eret_target,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        kernel,
  output logic        flush_if,
  output logic        flush_id,
  output logic        k0_we,
  output logic [31:0] k0_data,
  output logic        irq_ack
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [31:0]            pc_q, pc_d;
  logic                   kernel_q, kernel_d;
  logic                   k0_we_q, k0_we_d;
  logic [31:0]            k0_data_q, k0_data_d;
  logic                   flush_if_c, flush_id_c, irq_ack_c;
  logic                   irq_s, irq_pend, exc_take, irq_take;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], irq_in};
  assign irq_s    = sync_q[SYNC_STAGES-1];
  // Level-sensitive: the handler must clear the timer before returning.
  assign irq_pend = irq_s & ~kernel_q;
  assign exc_take = id_valid & id_undef & ~stall;
  assign irq_take = irq_pend & id_valid & ~stall;

  always_comb begin
    pc_d       = pc_q + 32'd4;
    kernel_d   = kernel_q;
    k0_we_d    = 1'b0;
    k0_data_d  = k0_data_q;
    flush_if_c = 1'b0;
    flush_id_c = 1'b0;
    irq_ack_c  = 1'b0;
    if (branch_req) begin
      // A resolved branch kills everything younger, including a stalled ID.
      pc_d       = branch_target;
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
    end else if (exc_take) begin
      // Return skips the offending instruction.
      pc_d       = EXC_VEC;
      kernel_d   = 1'b1;
      k0_we_d    = 1'b1;
      k0_data_d  = id_pc + 32'd4;
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
    end else if (irq_take) begin
      // Return re-executes the interrupted ID instruction.
      pc_d       = IRQ_VEC;
      kernel_d   = 1'b1;
      k0_we_d    = 1'b1;
      k0_data_d  = id_pc;
      irq_ack_c  = 1'b1;
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
    end else if (eret_req && !stall) begin
      pc_d       = eret_target;
      kernel_d   = 1'b0;
      flush_if_c = 1'b1;
    end else if (jump_req && !stall) begin
      pc_d       = jump_target;
      flush_if_c = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      pc_q      <= RESET_VEC;
      kernel_q  <= 1'b0;
      k0_we_q   <= 1'b0;
      k0_data_q <= 32'd0;
    end else begin
      sync_q    <= sync_d;
      pc_q      <= pc_d;
      kernel_q  <= kernel_d;
      k0_we_q   <= k0_we_d;
      k0_data_q <= k0_data_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign kernel   = kernel_q;
  assign k0_we    = k0_we_q;
  assign k0_data  = k0_data_q;
  // Combinational strobes are held quiet while reset is asserted.
  assign flush_if = flush_if_c & reset;
  assign flush_id = flush_id_c & reset;
  assign irq_ack  = irq_ack_c & reset;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Purpose: self-checking bench for fetch_pc_sequencer; directed scenarios plus randomized traffic against a behavioural model.
// Latency: inputs change 1ns after a rising edge; outputs are checked 2ns later, well before the next edge.
// Backpressure: stall is randomized like any other input.
module tb_fetch_pc_sequencer;
  localparam int SYNC = 2;
  localparam int A_NONE = 0, A_BR = 1, A_EXC = 2, A_IRQ = 3, A_ERET = 4, A_JMP = 5, A_HOLD = 6, A_SEQ = 7;

  logic        clk, reset, irq_in, stall, id_valid, id_undef;
  logic        jump_req, eret_req, branch_req;
  logic [31:0] id_pc, jump_target, eret_target, branch_target;
  logic [31:0] pc, pc_plus4, k0_data;
  logic        kernel, flush_if, flush_id, k0_we, irq_ack;

  int n_pass = 0;
  int n_chk  = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_k0_data;
  logic        m_kernel, m_k0_we;
  logic        hist [SYNC];   // hist[k] = irq_in as sampled k+1 edges ago

  fetch_pc_sequencer dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .stall(stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_undef(id_undef),
    .jump_req(jump_req), .jump_target(jump_target),
    .eret_req(eret_req), .eret_target(eret_target),
    .branch_req(branch_req), .branch_target(branch_target),
    .pc(pc), .pc_plus4(pc_plus4), .kernel(kernel),
    .flush_if(flush_if), .flush_id(flush_id),
    .k0_we(k0_we), .k0_data(k0_data), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_kernel = 1'b0; m_k0_we = 1'b0; m_k0_data = 32'h0;
    for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
  endtask

  // Which redirect wins this cycle, straight from the priority rules.
  function automatic int decide();
    if (!reset)                                           return A_NONE;
    if (branch_req)                                       return A_BR;
    if (id_valid && id_undef && !stall)                   return A_EXC;
    if (hist[SYNC-1] && !m_kernel && id_valid && !stall)  return A_IRQ;
    if (eret_req && !stall)                               return A_ERET;
    if (jump_req && !stall)                               return A_JMP;
    if (stall)                                            return A_HOLD;
    return A_SEQ;
  endfunction

  task automatic apply(input int a);
    logic [31:0] npc;
    case (a)
      A_BR:    npc = branch_target;
      A_EXC:   npc = 32'h8;
      A_IRQ:   npc = 32'h4;
      A_ERET:  npc = eret_target;
      A_JMP:   npc = jump_target;
      A_HOLD:  npc = m_pc;
      default: npc = m_pc + 32'd4;
    endcase
    m_pc = npc;
    if (a == A_EXC || a == A_IRQ) m_kernel = 1'b1;
    if (a == A_ERET) m_kernel = 1'b0;
    if (a == A_EXC) m_k0_data = id_pc + 32'd4;
    if (a == A_IRQ) m_k0_data = id_pc;
    m_k0_we = (a == A_EXC || a == A_IRQ);
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = irq_in;
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic step();
    int a;
    #2;
    if (!reset) model_reset();
    a = decide();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("kernel", {31'd0, kernel}, {31'd0, m_kernel});
    chk("k0_we", {31'd0, k0_we}, {31'd0, m_k0_we});
    if (m_k0_we || !reset) chk("k0_data", k0_data, m_k0_data);
    chk("flush_if", {31'd0, flush_if},
        {31'd0, (a == A_BR || a == A_EXC || a == A_IRQ || a == A_ERET || a == A_JMP)});
    chk("flush_id", {31'd0, flush_id}, {31'd0, (a == A_BR || a == A_EXC || a == A_IRQ)});
    chk("irq_ack", {31'd0, irq_ack}, {31'd0, (a == A_IRQ)});
    @(posedge clk);
    if (!reset) model_reset(); else apply(a);
    #1;
  endtask

  initial begin
    reset = 1'b0; irq_in = 1'b0; stall = 1'b0; id_valid = 1'b0; id_undef = 1'b0;
    jump_req = 1'b0; eret_req = 1'b0; branch_req = 1'b1;
    id_pc = 32'h0; jump_target = 32'h0; eret_target = 32'h0; branch_target = 32'h100;
    model_reset();
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_kernel", {31'd0, kernel}, 32'd0);
    chk("rst_k0_we", {31'd0, k0_we}, 32'd0);
    chk("rst_flush_if", {31'd0, flush_if}, 32'd0);
    step(); step();
    branch_req = 1'b0;
    reset = 1'b1;

    // Free run from reset
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc, 32'(i * 4));
      step();
    end

    // Interrupt entry through the synchroniser
    irq_in = 1'b1; id_valid = 1'b1; id_pc = 32'h30;
    step(); step();
    #2;
    chk("irq_ack_entry", {31'd0, irq_ack}, 32'd1);
    chk("irq_flush_id", {31'd0, flush_id}, 32'd1);
    step();
    chk("irq_pc", pc, 32'h4);
    chk("irq_k0_we", {31'd0, k0_we}, 32'd1);
    chk("irq_k0_data", k0_data, 32'h30);
    chk("irq_kernel", {31'd0, kernel}, 32'd1);

    // Masked in kernel, return, re-entry on the return target
    id_valid = 1'b0; step();
    id_valid = 1'b1; id_pc = 32'h8;
    #2; chk("masked_ack", {31'd0, irq_ack}, 32'd0);
    step();
    eret_req = 1'b1; eret_target = 32'h30;
    #2;
    chk("eret_flush_if", {31'd0, flush_if}, 32'd1);
    chk("eret_flush_id", {31'd0, flush_id}, 32'd0);
    step();
    eret_req = 1'b0;
    chk("eret_pc", pc, 32'h30);
    chk("eret_kernel", {31'd0, kernel}, 32'd0);
    id_valid = 1'b0;
    #2; chk("noid_ack", {31'd0, irq_ack}, 32'd0);
    step();
    id_valid = 1'b1; id_pc = 32'h30;
    #2; chk("reentry_ack", {31'd0, irq_ack}, 32'd1);
    step();
    chk("reentry_k0_data", k0_data, 32'h30);
    chk("reentry_pc", pc, 32'h4);
    irq_in = 1'b0; id_valid = 1'b0;
    step(); step(); step();
    eret_req = 1'b1; eret_target = 32'h40; step();
    eret_req = 1'b0;

    // Undefined instruction
    id_valid = 1'b1; id_pc = 32'h50; id_undef = 1'b1;
    #2; chk("exc_flush_id", {31'd0, flush_id}, 32'd1);
    step();
    id_undef = 1'b0; id_valid = 1'b0;
    chk("exc_pc", pc, 32'h8);
    chk("exc_k0_data", k0_data, 32'h54);
    chk("exc_kernel", {31'd0, kernel}, 32'd1);
    eret_req = 1'b1; eret_target = 32'h60; step();
    eret_req = 1'b0;

    // Branch beats irq under stall; stall delays irq
    irq_in = 1'b1; step(); step();
    branch_req = 1'b1; branch_target = 32'h5C; stall = 1'b1; id_valid = 1'b1; id_pc = 32'h58;
    #2; chk("br_irq_ack", {31'd0, irq_ack}, 32'd0);
    step();
    chk("br_pc", pc, 32'h5C);
    branch_req = 1'b0;
    #2; chk("stall_irq_ack", {31'd0, irq_ack}, 32'd0);
    step();
    chk("stall_pc", pc, 32'h5C);
    stall = 1'b0;
    #2; chk("unstall_irq_ack", {31'd0, irq_ack}, 32'd1);
    step();
    chk("unstall_pc", pc, 32'h4);

    // Async reset while k0 write pending
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_pc", pc, 32'h0);
    chk("arst_kernel", {31'd0, kernel}, 32'd0);
    chk("arst_k0_we", {31'd0, k0_we}, 32'd0);
    branch_req = 1'b1;
    step();
    reset = 1'b1; branch_req = 1'b0; irq_in = 1'b0; id_valid = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) irq_in = ~irq_in;
      stall      = ($urandom_range(0, 4) == 0);
      branch_req = ($urandom_range(0, 9) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_undef   = ($urandom_range(0, 11) == 0);
      eret_req   = m_kernel && ($urandom_range(0, 3) == 0);
      jump_req   = !eret_req && ($urandom_range(0, 4) == 0);
      id_pc         = $urandom;
      jump_target   = $urandom;
      eret_target   = $urandom;
      branch_target = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
